// File: rtl/calc_pkg.sv
// Shared encodings and widths for the hex calculator front end.
package calc_pkg;

    localparam int RES_W = 32;
    localparam int NUM_W = 8;

    typedef enum logic [2:0] {
        FUNC_ADD = 3'b000,
        FUNC_SUB = 3'b001,
        FUNC_MUL = 3'b010,
        FUNC_DIV = 3'b011,
        FUNC_MOD = 3'b100,
        FUNC_SQR = 3'b101
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_COMMIT
    } state_e;

    // Codes 11x have no ALU operation behind them.
    function automatic logic func_valid(input logic [2:0] f);
        return f <= FUNC_SQR;
    endfunction

endpackage

// File: rtl/calc_debounce.sv
// Button synchroniser and debounce filter; emits a single-cycle pulse on each accepted press.
module calc_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: combinational logic uses blocking '=' with defaults first, so no latch is inferred.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        // Any cycle where the synced level matches the filtered level restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    // NOTE: state flops use non-blocking '<=' and take the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator front-end: debounced operator button drives one ALU operation per press over a
// start/done handshake, accumulating and chaining the result.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ALU_TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             button,
    input  logic             clear,
    input  logic [2:0]       func,
    input  logic [NUM_W-1:0] num1,
    input  logic [NUM_W-1:0] num2,
    output logic             alu_start,
    output logic [2:0]       alu_op,
    output logic [RES_W-1:0] alu_a,
    output logic [RES_W-1:0] alu_b,
    input  logic             alu_done,
    input  logic             alu_err,
    input  logic [RES_W-1:0] alu_result,
    output logic [RES_W-1:0] cal_result,
    output logic             busy,
    output logic             chain,
    output logic             err
);

    localparam int TMO_W = $clog2(ALU_TIMEOUT + 1);

    logic press;

    calc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .button (button),
        .press  (press)
    );

    state_e           state_q, state_d;
    logic             alu_start_q, alu_start_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [RES_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [RES_W-1:0] res_q, res_d, cal_result_q, cal_result_d;
    logic             busy_q, busy_d, chain_q, chain_d, err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [RES_W-1:0] opa;

    always_comb begin
        state_d      = state_q;
        alu_start_d  = 1'b0;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        res_d        = res_q;
        cal_result_d = cal_result_q;
        chain_d      = chain_q;
        err_d        = err_q;
        tmo_d        = tmo_q;
        opa          = chain_q ? cal_result_q : RES_W'(num1);

        unique case (state_q)
            ST_IDLE: begin
                if (press && !clear && func_valid(func)) begin
                    state_d     = ST_ISSUE;
                    alu_start_d = 1'b1;
                    alu_op_d    = func;
                    alu_a_d     = opa;
                    alu_b_d     = (func == FUNC_SQR) ? opa : RES_W'(num2);
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                tmo_d   = '0;
            end
            ST_WAIT: begin
                if (alu_done) begin
                    if (alu_err) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        res_d   = alu_result;
                        state_d = ST_COMMIT;
                    end
                end else if (tmo_q == TMO_W'(ALU_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                cal_result_d = res_q;
                chain_d      = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear overrides everything, including a pending commit.
        if (clear) begin
            state_d      = ST_IDLE;
            cal_result_d = '0;
            chain_d      = 1'b0;
            err_d        = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alu_start_q  <= 1'b0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            res_q        <= '0;
            cal_result_q <= '0;
            busy_q       <= 1'b0;
            chain_q      <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            alu_start_q  <= alu_start_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            res_q        <= res_d;
            cal_result_q <= cal_result_d;
            busy_q       <= busy_d;
            chain_q      <= chain_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign alu_start  = alu_start_q;
    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign cal_result = cal_result_q;
    assign busy       = busy_q;
    assign chain      = chain_q;
    assign err        = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with a 3-cycle ALU model.
module tb_calc_op_sequencer;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, button, clear;
    logic [2:0]  func;
    logic [7:0]  num1, num2;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [31:0] alu_a, alu_b, cal_result;
    logic        busy, chain, err;
    logic        alu_done = 1'b0;
    logic        alu_err = 1'b0;
    logic [31:0] alu_result = '0;

    calc_op_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .button(button), .clear(clear), .func(func),
        .num1(num1), .num2(num2), .alu_start(alu_start), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done), .alu_err(alu_err),
        .alu_result(alu_result), .cal_result(cal_result), .busy(busy),
        .chain(chain), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ALU model: done pulse three cycles after the start pulse, unless told to hang.
    bit          hang = 1'b0;
    int          m_cnt = 0;
    logic [2:0]  m_op = '0;
    logic [31:0] m_a = '0, m_b = '0;

    always @(negedge clk) begin
        alu_done = 1'b0;
        alu_err  = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                alu_done = 1'b1;
                case (m_op)
                    FUNC_ADD: alu_result = m_a + m_b;
                    FUNC_SUB: alu_result = m_a - m_b;
                    FUNC_MUL, FUNC_SQR: alu_result = m_a * m_b;
                    FUNC_DIV: alu_result = (m_b == 0) ? 32'h0 : m_a / m_b;
                    default:  alu_result = (m_b == 0) ? 32'h0 : m_a % m_b;
                endcase
                alu_err = (m_op == FUNC_DIV || m_op == FUNC_MOD) && (m_b == 0);
            end
        end
        if (alu_start && !hang) begin
            m_cnt = 3;
            m_op  = alu_op;
            m_a   = alu_a;
            m_b   = alu_b;
        end
    end

    int          start_cnt = 0;
    logic [31:0] cap_a = '0, cap_b = '0;
    logic [2:0]  cap_op = '0;

    always @(negedge clk) begin
        if (alu_start) begin
            start_cnt++;
            cap_a  = alu_a;
            cap_b  = alu_b;
            cap_op = alu_op;
        end
    end

    typedef struct {
        logic [2:0]  func;
        logic [7:0]  num1, num2;
        logic [31:0] exp_a, exp_b, exp_res;
        logic        exp_chain, exp_err, exp_start;
    } vec_t;

    vec_t vecs[11];

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_idle"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_start(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (alu_start) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_start_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s0;
        s0   = start_cnt;
        func = v.func;
        num1 = v.num1;
        num2 = v.num2;
        button = 1'b1;
        settle(20);
        button = 1'b0;
        settle(12);
        wait_idle(tag);
        check({tag, "_starts"}, 32'(start_cnt - s0), 32'(v.exp_start));
        if (v.exp_start) begin
            check({tag, "_op"}, 32'(cap_op), 32'(v.func));
            check({tag, "_a"}, cap_a, v.exp_a);
            check({tag, "_b"}, cap_b, v.exp_b);
        end
        check({tag, "_result"}, cal_result, v.exp_res);
        check({tag, "_chain"}, 32'(chain), 32'(v.exp_chain));
        check({tag, "_err"}, 32'(err), 32'(v.exp_err));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_start"}, 32'(alu_start), 32'd0);
        check({tag, "_op"}, 32'(alu_op), 32'd0);
        check({tag, "_a"}, alu_a, 32'd0);
        check({tag, "_b"}, alu_b, 32'd0);
        check({tag, "_result"}, cal_result, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_chain"}, 32'(chain), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int s0;
        vecs[0]  = '{FUNC_ADD, 8'h12, 8'h34, 32'h12, 32'h34, 32'h46, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{FUNC_MUL, 8'h55, 8'h10, 32'h46, 32'h10, 32'h460, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{FUNC_SQR, 8'h55, 8'h99, 32'h460, 32'h460, 32'h132400, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{FUNC_SUB, 8'h00, 8'hFF, 32'h132400, 32'hFF, 32'h132301, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{FUNC_DIV, 8'h00, 8'h10, 32'h132301, 32'h10, 32'h13230, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{FUNC_MOD, 8'h00, 8'h07, 32'h13230, 32'h7, 32'h5, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{FUNC_SUB, 8'h00, 8'h08, 32'h5, 32'h8, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{FUNC_ADD, 8'h00, 8'h04, 32'hFFFF_FFFD, 32'h4, 32'h1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{FUNC_DIV, 8'h00, 8'h00, 32'h1, 32'h0, 32'h1, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{FUNC_ADD, 8'h00, 8'h04, 32'h1, 32'h4, 32'h5, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{3'b110, 8'h00, 8'h04, 32'h0, 32'h0, 32'h5, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0; button = 1'b0; clear = 1'b0;
        func = '0; num1 = '0; num2 = '0;
        settle(3);
        check_zero("reset");
        rst_n = 1'b1;
        settle(3);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Commit latency: done at S+3, result and busy change at S+5.
        func = FUNC_SUB; num2 = 8'h02;
        button = 1'b1;
        wait_start("lat");
        settle(4);
        check("lat_busy_commit", 32'(busy), 32'd1);
        check("lat_result_old", cal_result, 32'h5);
        settle(1);
        check("lat_busy_done", 32'(busy), 32'd0);
        check("lat_result_new", cal_result, 32'h3);
        button = 1'b0;
        settle(12);

        // Bounce 1-0-1 then hold: one operation.
        s0 = start_cnt;
        func = FUNC_ADD; num2 = 8'h01;
        button = 1'b1; settle(2);
        button = 1'b0; settle(2);
        button = 1'b1; settle(20);
        button = 1'b0; settle(12);
        check("bounce_starts", 32'(start_cnt - s0), 32'd1);
        check("bounce_result", cal_result, 32'h4);

        // Clear while idle.
        clear = 1'b1; settle(1); clear = 1'b0; settle(1);
        check("clr_idle_result", cal_result, 32'h0);
        check("clr_idle_chain", 32'(chain), 32'd0);
        check("clr_idle_err", 32'(err), 32'd0);

        // Timeout: eight WAIT cycles then abandon.
        hang = 1'b1;
        func = FUNC_ADD; num1 = 8'h03; num2 = 8'h01;
        button = 1'b1;
        wait_start("tmo");
        settle(8);
        check("tmo_busy_last_wait", 32'(busy), 32'd1);
        check("tmo_err_before", 32'(err), 32'd0);
        settle(1);
        check("tmo_busy_after", 32'(busy), 32'd0);
        check("tmo_err_after", 32'(err), 32'd1);
        check("tmo_result", cal_result, 32'h0);
        button = 1'b0;
        settle(12);

        // Second accepted press lands while the first op is still waiting: dropped.
        s0 = start_cnt;
        button = 1'b1; settle(4);
        button = 1'b0; settle(4);
        button = 1'b1; settle(12);
        button = 1'b0; settle(12);
        check("drop_starts", 32'(start_cnt - s0), 32'd1);
        check("drop_busy", 32'(busy), 32'd0);
        hang = 1'b0;

        run_vec('{FUNC_ADD, 8'h20, 8'h22, 32'h20, 32'h22, 32'h42, 1'b1, 1'b1, 1'b1}, "pre_clr");

        // Clear during WAIT, done arrives the following cycle.
        s0 = start_cnt;
        func = FUNC_ADD; num2 = 8'h01;
        button = 1'b1;
        wait_start("clrw");
        settle(2);
        clear = 1'b1;
        settle(1);
        clear = 1'b0;
        button = 1'b0;
        settle(12);
        check("clrw_starts", 32'(start_cnt - s0), 32'd1);
        check("clrw_result", cal_result, 32'h0);
        check("clrw_chain", 32'(chain), 32'd0);
        check("clrw_err", 32'(err), 32'd0);
        check("clrw_busy", 32'(busy), 32'd0);

        // Clear held across a press: press ignored.
        s0 = start_cnt;
        clear = 1'b1;
        button = 1'b1; settle(20);
        button = 1'b0; settle(12);
        clear = 1'b0;
        check("clrp_starts", 32'(start_cnt - s0), 32'd0);

        run_vec('{FUNC_ADD, 8'h07, 8'h08, 32'h7, 32'h8, 32'hF, 1'b1, 1'b0, 1'b1}, "post_clr");

        // Asynchronous reset mid-WAIT.
        func = FUNC_MUL; num2 = 8'h02;
        button = 1'b1;
        wait_start("rst");
        settle(2);
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        button = 1'b0;
        settle(2);
        rst_n = 1'b1;
        settle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
